// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported, variable-latency memory between the
// instruction-fetch stage (read-only) and the memory stage (read/write).
// Each level request becomes exactly one req/ack memory transaction, followed
// by a one-cycle done pulse. Data normally wins contention, but IF is forced
// through after FAIR_MAX consecutive data wins. A watchdog aborts grants that
// never see m_ack and raises a sticky bus_err.
module mem_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int FAIR_MAX = 4,
  parameter int TIMEOUT  = 64
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_done,
  output logic          if_stall,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_done,
  output logic          d_stall,
  output logic          m_req,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  input  logic          m_ack,
  output logic          bus_err
);

  localparam int FW = (FAIR_MAX > 0) ? $clog2(FAIR_MAX + 1) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [FW-1:0] FAIR_LIM = FW'(FAIR_MAX);
  localparam logic [TW-1:0] TMAX     = TW'(TIMEOUT - 1);
  localparam logic [DW-1:0] ERR_WORD = DW'(32'hDEADBEEF);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] GNT_I  = 3'd1;
  localparam logic [2:0] GNT_D  = 3'd2;
  localparam logic [2:0] DONE_I = 3'd3;
  localparam logic [2:0] DONE_D = 3'd4;

  logic [2:0]    state;
  logic [FW-1:0] fair_cnt;
  logic [TW-1:0] timer;
  logic          pick_d;
  logic          timed_out;

  // Data wins unless IF is also waiting and data has used up its fairness budget.
  assign pick_d    = d_req & (~if_req | (fair_cnt < FAIR_LIM));
  assign timed_out = (timer == TMAX);

  // Stalls release combinationally in the done cycle so the stage advances on that edge.
  assign if_stall = if_req & ~if_done;
  assign d_stall  = d_req & ~d_done;

  // Arbitration FSM, memory-side registers, read-data capture and watchdog.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      m_req    <= 1'b0;
      m_we     <= 1'b0;
      m_addr   <= '0;
      m_wdata  <= '0;
      if_rdata <= '0;
      d_rdata  <= '0;
      if_done  <= 1'b0;
      d_done   <= 1'b0;
      bus_err  <= 1'b0;
      fair_cnt <= '0;
      timer    <= '0;
    end else begin
      if_done <= 1'b0;
      d_done  <= 1'b0;
      case (state)
        IDLE: begin
          timer <= '0;
          if (pick_d) begin
            state   <= GNT_D;
            m_req   <= 1'b1;
            m_we    <= d_we;
            m_addr  <= d_addr;
            m_wdata <= d_wdata;
            // Only wins against a waiting fetch count toward unfairness.
            if (if_req && (fair_cnt != FAIR_LIM)) fair_cnt <= fair_cnt + 1'b1;
          end else if (if_req) begin
            state    <= GNT_I;
            m_req    <= 1'b1;
            m_we     <= 1'b0;
            m_addr   <= if_addr;
            fair_cnt <= '0;
          end
        end
        GNT_I, GNT_D: begin
          if (m_ack || timed_out) begin
            // Ack wins over a simultaneous timeout; either way the access ends here.
            m_req <= 1'b0;
            m_we  <= 1'b0;
            timer <= '0;
            if (!m_ack) bus_err <= 1'b1;
            if (state == GNT_I) begin
              state    <= DONE_I;
              if_done  <= 1'b1;
              if_rdata <= m_ack ? m_rdata : ERR_WORD;
            end else begin
              state  <= DONE_D;
              d_done <= 1'b1;
              if (!m_we) d_rdata <= m_ack ? m_rdata : ERR_WORD;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        // Requests seen here are ignored; the requester updates at this edge.
        DONE_I, DONE_D: state <= IDLE;
        default:        state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed tests for mem_arbiter. Inputs are driven and outputs
// sampled 2 time units after each rising edge; "cycle n" counts from the edge
// that leaves the IDLE cycle in which a request is first presented.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TIMEOUT = 64;

  logic          clock, reset;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_done, if_stall;
  logic          d_req, d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic          d_done, d_stall;
  logic          m_req, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;
  logic          m_ack, bus_err;

  int vecs = 0;
  int errs = 0;

  mem_arbiter #(.AW(AW), .DW(DW), .FAIR_MAX(4), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .if_done(if_done), .if_stall(if_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done), .d_stall(d_stall),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ack(m_ack), .bus_err(bus_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic test_reset();
    reset = 1'b1; if_req = 0; if_addr = '0; d_req = 0; d_we = 0;
    d_addr = '0; d_wdata = '0; m_rdata = '0; m_ack = 0;
    step(); step();
    vecs++;
    if (m_req !== 0 || m_we !== 0 || if_done !== 0 || d_done !== 0 || bus_err !== 0)
      begin errs++; $display("FAIL reset_ctl got req=%b we=%b idn=%b ddn=%b err=%b exp all 0",
        m_req, m_we, if_done, d_done, bus_err); end
    vecs++;
    if (m_addr !== 0 || m_wdata !== 0 || if_rdata !== 0 || d_rdata !== 0)
      begin errs++; $display("FAIL reset_data got addr=%h wd=%h ird=%h drd=%h exp 0",
        m_addr, m_wdata, if_rdata, d_rdata); end
    reset = 1'b0;
    step();
  endtask

  // Ack arrives on the second m_req cycle (cycle 2), so done is at cycle 3.
  task automatic test_fetch();
    if_req = 1; if_addr = 32'h100;
    #1;
    vecs++;
    if (if_stall !== 1) begin errs++; $display("FAIL fetch_stall0 got %b exp 1", if_stall); end
    step();
    vecs++;
    if (m_req !== 1 || m_addr !== 32'h100 || m_we !== 0 || if_stall !== 1)
      begin errs++; $display("FAIL fetch_c1 got req=%b addr=%h we=%b stall=%b exp 1/100/0/1",
        m_req, m_addr, m_we, if_stall); end
    step();
    m_ack = 1; m_rdata = 32'h8C220004;
    vecs++;
    if (m_req !== 1 || m_addr !== 32'h100 || m_we !== 0 || if_done !== 0)
      begin errs++; $display("FAIL fetch_c2 got req=%b addr=%h we=%b done=%b exp 1/100/0/0",
        m_req, m_addr, m_we, if_done); end
    step();
    m_ack = 0; if_req = 0;
    #1;
    vecs++;
    if (if_done !== 1 || if_rdata !== 32'h8C220004 || m_req !== 0 || if_stall !== 0 || d_done !== 0)
      begin errs++; $display("FAIL fetch_done got done=%b rdata=%h req=%b stall=%b exp 1/8c220004/0/0",
        if_done, if_rdata, m_req, if_stall); end
    step();
    vecs++;
    if (if_done !== 0 || m_req !== 0)
      begin errs++; $display("FAIL fetch_idle got done=%b req=%b exp 0/0", if_done, m_req); end
  endtask

  task automatic test_read();
    d_req = 1; d_we = 0; d_addr = 32'h80;
    step();
    m_ack = 1; m_rdata = 32'h12345678;
    vecs++;
    if (m_req !== 1 || m_we !== 0 || m_addr !== 32'h80)
      begin errs++; $display("FAIL read_gnt got req=%b we=%b addr=%h exp 1/0/80", m_req, m_we, m_addr); end
    step();
    m_ack = 0; d_req = 0;
    vecs++;
    if (d_done !== 1 || d_rdata !== 32'h12345678 || if_done !== 0)
      begin errs++; $display("FAIL read_done got done=%b rdata=%h exp 1/12345678", d_done, d_rdata); end
    step();
  endtask

  task automatic test_write();
    d_req = 1; d_we = 1; d_addr = 32'h40; d_wdata = 32'hCAFEF00D;
    step();
    m_ack = 1; m_rdata = 32'hFFFFFFFF;
    vecs++;
    if (m_req !== 1 || m_we !== 1 || m_addr !== 32'h40 || m_wdata !== 32'hCAFEF00D)
      begin errs++; $display("FAIL write_gnt got req=%b we=%b addr=%h wd=%h exp 1/1/40/cafef00d",
        m_req, m_we, m_addr, m_wdata); end
    step();
    m_ack = 0; d_req = 0; d_we = 0;
    vecs++;
    if (d_done !== 1 || d_rdata !== 32'h12345678 || m_we !== 0 || m_req !== 0)
      begin errs++; $display("FAIL write_done got done=%b rdata=%h we=%b req=%b exp 1/12345678/0/0",
        d_done, d_rdata, m_we, m_req); end
    step();
    vecs++;
    if (d_done !== 0) begin errs++; $display("FAIL write_pulse got %b exp 0", d_done); end
  endtask

  task automatic test_contention();
    logic [0:9]    seq;
    logic [AW-1:0] exp_addr;
    seq = 10'b1111011110;
    if_addr = 32'h1000; d_addr = 32'h2000; d_we = 0;
    if_req = 1; d_req = 1;
    for (int g = 0; g < 10; g++) begin
      step();
      exp_addr = seq[g] ? 32'h2000 : 32'h1000;
      vecs++;
      if (m_req !== 1 || m_addr !== exp_addr)
        begin errs++; $display("FAIL contend_gnt%0d got req=%b addr=%h exp 1/%h", g, m_req, m_addr, exp_addr); end
      m_ack = 1; m_rdata = 32'hA0000000 + 32'(g);
      step();
      m_ack = 0;
      vecs++;
      if (d_done !== seq[g] || if_done !== ~seq[g])
        begin errs++; $display("FAIL contend_done%0d got d=%b i=%b exp d=%b", g, d_done, if_done, seq[g]); end
      if (g == 9) begin if_req = 0; d_req = 0; end
      step();
    end
    vecs++;
    if (if_rdata !== 32'hA0000009 || d_rdata !== 32'hA0000008 || bus_err !== 0)
      begin errs++; $display("FAIL contend_rdata got i=%h d=%h err=%b exp a0000009/a0000008/0",
        if_rdata, d_rdata, bus_err); end
  endtask

  // Request stays high through DONE_I while the address advances; DONE must not re-grant.
  task automatic test_back_to_back();
    if_req = 1; if_addr = 32'h200;
    step();
    m_ack = 1; m_rdata = 32'h11111111;
    step();
    m_ack = 0; if_addr = 32'h204;
    vecs++;
    if (if_done !== 1 || m_req !== 0)
      begin errs++; $display("FAIL b2b_done1 got done=%b req=%b exp 1/0", if_done, m_req); end
    step();
    vecs++;
    if (m_req !== 0 || if_done !== 0)
      begin errs++; $display("FAIL b2b_idle got req=%b done=%b exp 0/0", m_req, if_done); end
    step();
    vecs++;
    if (m_req !== 1 || m_addr !== 32'h204)
      begin errs++; $display("FAIL b2b_gnt2 got req=%b addr=%h exp 1/204", m_req, m_addr); end
    m_ack = 1; m_rdata = 32'h22222222;
    step();
    m_ack = 0; if_req = 0;
    vecs++;
    if (if_done !== 1 || if_rdata !== 32'h22222222)
      begin errs++; $display("FAIL b2b_done2 got done=%b rdata=%h exp 1/22222222", if_done, if_rdata); end
    step();
  endtask

  task automatic test_timeout();
    int bad;
    bad = 0;
    d_req = 1; d_we = 0; d_addr = 32'h300;
    for (int i = 1; i <= TIMEOUT; i++) begin
      step();
      if (m_req !== 1 || d_done !== 0 || bus_err !== 0) bad++;
    end
    vecs++;
    if (bad != 0) begin errs++; $display("FAIL tmo_hold got %0d bad cycles exp 0", bad); end
    step();
    d_req = 0;
    vecs++;
    if (m_req !== 0 || d_done !== 1 || d_rdata !== 32'hDEADBEEF || bus_err !== 1)
      begin errs++; $display("FAIL tmo_abort got req=%b done=%b rdata=%h err=%b exp 0/1/deadbeef/1",
        m_req, d_done, d_rdata, bus_err); end
    step();
    m_ack = 1; m_rdata = 32'h55555555;
    step();
    m_ack = 0;
    vecs++;
    if (m_req !== 0 || d_done !== 0 || if_done !== 0 || d_rdata !== 32'hDEADBEEF || bus_err !== 1)
      begin errs++; $display("FAIL tmo_late_ack got req=%b done=%b rdata=%h err=%b exp 0/0/deadbeef/1",
        m_req, d_done, d_rdata, bus_err); end
    step();
  endtask

  // Four data wins over a waiting fetch saturate fair_cnt; reset must clear it so data wins next.
  task automatic test_reset_mid();
    int bad;
    bad = 0;
    if_addr = 32'h1000; d_addr = 32'h2000; d_we = 0;
    if_req = 1; d_req = 1;
    for (int g = 0; g < 3; g++) begin
      step();
      m_ack = 1; m_rdata = 32'h0;
      step();
      m_ack = 0;
      step();
    end
    step();
    vecs++;
    if (m_req !== 1 || m_addr !== 32'h2000)
      begin errs++; $display("FAIL rst_pre got req=%b addr=%h exp 1/2000", m_req, m_addr); end
    reset = 1;
    step();
    reset = 0;
    vecs++;
    if (m_req !== 0 || d_done !== 0 || bus_err !== 0 || if_done !== 0)
      begin errs++; $display("FAIL rst_mid got req=%b done=%b err=%b exp 0/0/0", m_req, d_done, bus_err); end
    step();
    if (d_done !== 0) bad++;
    vecs++;
    if (m_req !== 1 || m_addr !== 32'h2000)
      begin errs++; $display("FAIL rst_fair got req=%b addr=%h exp 1/2000", m_req, m_addr); end
    m_ack = 1; m_rdata = 32'h77777777;
    step();
    m_ack = 0; if_req = 0; d_req = 0;
    vecs++;
    if (bad != 0 || d_done !== 1 || d_rdata !== 32'h77777777)
      begin errs++; $display("FAIL rst_after got done=%b rdata=%h early=%0d exp 1/77777777/0",
        d_done, d_rdata, bad); end
    step();
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_read();
    test_write();
    test_contention();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  // Done pulses must be mutually exclusive.
  always @(negedge clock) begin
    if (!reset && if_done === 1'b1 && d_done === 1'b1) begin
      errs++;
      $display("FAIL done_overlap got both done high exp exclusive");
    end
  end

endmodule
